bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 97 +++++++++
 tb/tb_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 8-source common bus with multi-cycle hold.
// The hold counter caps ownership at MAX_HOLD cycles while others are waiting.
module bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] hold,
  output logic [2:0] selects,
  output logic [7:0] gnt,
  output logic       bus_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [2:0]       sel_reg, sel_next;
  logic [7:0]       gnt_reg, gnt_next;
  logic             valid_reg, valid_next;

  logic [7:0] rot_req;
  logic [2:0] pick_off;
  logic [2:0] pick_idx;
  logic [7:0] others;
  logic       keep;

  // rot_req[gi] is the request seen gi places after the round-robin pointer
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  always_comb begin
    pick_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) pick_off = 3'(i);
    end
  end

  assign pick_idx = ptr_reg + pick_off;
  assign others   = req & ~gnt_reg;
  assign keep     = (state_reg == GRANT) && req[sel_reg] && hold[sel_reg] &&
                    ((hold_cnt_reg < CNT_W'(MAX_HOLD)) || (others == 8'd0));

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    sel_next      = sel_reg;
    gnt_next      = gnt_reg;
    valid_next    = valid_reg;
    if (keep) begin
      if (hold_cnt_reg != {CNT_W{1'b1}}) hold_cnt_next = hold_cnt_reg + 1'b1;
    end else if (req != 8'd0) begin
      // New grant straight from IDLE or a release, with no idle cycle between
      state_next    = GRANT;
      gnt_next      = 8'd1 << pick_idx;
      sel_next      = pick_idx;
      valid_next    = 1'b1;
      hold_cnt_next = CNT_W'(1);
      ptr_next      = pick_idx + 3'd1;
    end else begin
      state_next    = IDLE;
      gnt_next      = 8'd0;
      valid_next    = 1'b0;
      hold_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      hold_cnt_reg <= '0;
      sel_reg      <= 3'd0;
      gnt_reg      <= 8'd0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      sel_reg      <= sel_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= valid_next;
    end
  end

  assign selects   = sel_reg;
  assign gnt       = gnt_reg;
  assign bus_valid = valid_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, rotation, hold, forced release, reset mid-grant.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] hold;
  logic [2:0] selects;
  logic [7:0] gnt;
  logic       bus_valid;

  int tests_run = 0;
  int tests_failed = 0;

  bus_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .hold(hold),
    .selects(selects), .gnt(gnt), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00;
    hold = 8'h00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({gnt, selects, bus_valid} !== {8'h00, 3'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: gnt=%h sel=%0d valid=%b, want gnt=00 sel=0 valid=0", i, gnt, selects, bus_valid);
      end
      $display("[TB] reset_idle cyc%0d gnt=%h sel=%0d valid=%b", i, gnt, selects, bus_valid);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] eg;
    logic [2:0] es;
    do_reset();
    req = 8'b0010_0100;
    for (int i = 0; i < 6; i++) begin
      step();
      eg = (i % 2 == 0) ? 8'h04 : 8'h20;
      es = (i % 2 == 0) ? 3'd2 : 3'd5;
      tests_run++;
      if ({gnt, selects, bus_valid} !== {eg, es, 1'b1}) begin
        tests_failed++;
        $display("FAIL alternate cyc%0d: gnt=%h sel=%0d valid=%b, want gnt=%h sel=%0d valid=1", i, gnt, selects, bus_valid, eg, es);
      end
      $display("[TB] alternate cyc%0d gnt=%h sel=%0d", i, gnt, selects);
    end
  endtask

  task automatic test_hold_alone();
    do_reset();
    req = 8'h08;
    hold = 8'h08;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({gnt, selects, bus_valid} !== {8'h08, 3'd3, 1'b1}) begin
        tests_failed++;
        $display("FAIL hold_alone cyc%0d: gnt=%h sel=%0d valid=%b, want gnt=08 sel=3 valid=1", i, gnt, selects, bus_valid);
      end
      $display("[TB] hold_alone cyc%0d gnt=%h", i, gnt);
    end
  endtask

  task automatic test_forced_release();
    logic [7:0] eg [4] = '{8'h08, 8'h08, 8'h08, 8'h40};
    logic [2:0] es [4] = '{3'd3, 3'd3, 3'd3, 3'd6};
    do_reset();
    req = 8'h08;
    hold = 8'h08;
    step();   // owner 3, hold_cnt=1
    for (int i = 0; i < 4; i++) begin
      step(); // hold_cnt=2,3,4 then handover
      if (i == 0) req = 8'h48;
      tests_run++;
      if ({gnt, selects, bus_valid} !== {eg[i], es[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL forced_release cyc%0d: gnt=%h sel=%0d valid=%b, want gnt=%h sel=%0d valid=1", i, gnt, selects, bus_valid, eg[i], es[i]);
      end
      $display("[TB] forced_release cyc%0d gnt=%h sel=%0d", i, gnt, selects);
    end
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 8'h08;
    hold = 8'h08;
    step();
    req = 8'h02;
    step();
    tests_run++;
    if ({gnt, selects, bus_valid} !== {8'h02, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL drop_req: gnt=%h sel=%0d valid=%b, want gnt=02 sel=1 valid=1", gnt, selects, bus_valid);
    end
    $display("[TB] drop_req gnt=%h sel=%0d", gnt, selects);
  endtask

  task automatic test_round_robin_all();
    logic [2:0] es;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      step();
      es = 3'(i % 8);
      tests_run++;
      if ({gnt, selects, bus_valid} !== {8'h01 << es, es, 1'b1}) begin
        tests_failed++;
        $display("FAIL round_robin cyc%0d: gnt=%h sel=%0d valid=%b, want sel=%0d valid=1", i, gnt, selects, bus_valid, es);
      end
      $display("[TB] round_robin cyc%0d gnt=%h sel=%0d", i, gnt, selects);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h10;
    hold = 8'h10;
    step();
    step();
    tests_run++;
    if (gnt !== 8'h10) begin
      tests_failed++;
      $display("FAIL mid_grant_setup: gnt=%h, want 10", gnt);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if ({gnt, selects, bus_valid} !== {8'h00, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_grant_reset: gnt=%h sel=%0d valid=%b, want gnt=00 sel=0 valid=0", gnt, selects, bus_valid);
    end
    reset = 1'b0;
    req = 8'h11;
    hold = 8'h00;
    step();
    tests_run++;
    if ({gnt, selects, bus_valid} !== {8'h01, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_reset_grant: gnt=%h sel=%0d valid=%b, want gnt=01 sel=0 valid=1", gnt, selects, bus_valid);
    end
    step();
    tests_run++;
    if ({gnt, selects, bus_valid} !== {8'h10, 3'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_reset_next: gnt=%h sel=%0d valid=%b, want gnt=10 sel=4 valid=1", gnt, selects, bus_valid);
    end
    req = 8'h00;
    step();
    tests_run++;
    if ({gnt, selects, bus_valid} !== {8'h00, 3'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL release_idle: gnt=%h sel=%0d valid=%b, want gnt=00 sel=4 valid=0", gnt, selects, bus_valid);
    end
    $display("[TB] reset_mid_grant final gnt=%h sel=%0d valid=%b", gnt, selects, bus_valid);
  endtask

  initial begin
    reset = 1'b1;
    req = 8'h00;
    hold = 8'h00;
    test_reset();
    test_alternate();
    test_hold_alone();
    test_forced_release();
    test_drop_req();
    test_round_robin_all();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
